czono_plus_seq: RTL and testbench

Sequencer for the constrained-zonotope Minkowski-sum datapath. It accepts a start request with operand dimensions and validates them, including the Zn/Wn match and the NGMAX/NCMAX capacity limits. It then walks the center, generator, A-matrix and b-vector phases in order, issuing one read index per cycle and a one-cycle-delayed write index to the result memories. It replaces free-running iteration with an explicit start/busy/done/err handshake, so a host FSM can chain set operations.

---
 rtl/czono_plus_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_czono_plus_seq.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/czono_plus_seq.sv
// Index sequencer for the constrained-zonotope Minkowski-sum datapath.
// Walks center, generator, A-matrix and b-vector phases with a start/busy/done/err handshake.
module czono_plus_seq #(
  parameter  int NMAX  = 3,
  parameter  int NGMAX = 15,
  parameter  int NCMAX = 12,
  localparam int NW    = $clog2(NMAX),
  localparam int GW    = $clog2(NGMAX),
  localparam int CW    = $clog2(NCMAX)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [NW-1:0] Zn_i,
  input  logic [NW-1:0] Wn_i,
  input  logic [GW-1:0] Zng_i,
  input  logic [GW-1:0] Wng_i,
  input  logic [CW-1:0] Znc_i,
  input  logic [CW-1:0] Wnc_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          rd_en_o,
  output logic [1:0]    phase_o,
  output logic [CW:0]   row_o,
  output logic [GW:0]   col_o,
  output logic          src_w_o,
  output logic          zero_o,
  output logic          wr_en_o,
  output logic [1:0]    wr_phase_o,
  output logic [CW:0]   wr_row_o,
  output logic [GW:0]   wr_col_o,
  output logic          wr_src_w_o,
  output logic          wr_zero_o
);

  localparam int RW  = CW + 1;
  localparam int CLW = GW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CENTER,
    S_GEN,
    S_AMAT,
    S_BVEC,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [RW-1:0]    r_row;
  logic [RW-1:0]    w_row_nxt;
  logic [CLW-1:0]   r_col;
  logic [CLW-1:0]   w_col_nxt;

  logic [NW-1:0]    r_n;
  logic [CLW-1:0]   r_ng;
  logic [RW-1:0]    r_nc;
  logic [GW-1:0]    r_zng;
  logic [CW-1:0]    r_znc;
  logic             r_err;

  logic [CLW-1:0]   w_ng_in;
  logic [RW-1:0]    w_nc_in;
  logic             w_dims_ok;
  logic             w_idle;
  logic             w_accept;
  logic             w_row_last_n;
  logic             w_row_last_c;
  logic             w_col_last;
  logic             w_ng_zero;
  logic             w_nc_zero;
  logic             w_row_in_z;
  logic             w_col_in_z;

  // Dimension check happens on the raw inputs so err_o can pulse right after the start cycle.
  assign w_ng_in   = {1'b0, Zng_i} + {1'b0, Wng_i};
  assign w_nc_in   = {1'b0, Znc_i} + {1'b0, Wnc_i};
  assign w_dims_ok = (Zn_i == Wn_i) && (Zn_i != '0) &&
                     (w_ng_in <= CLW'(NGMAX)) && (w_nc_in <= RW'(NCMAX));
  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle && start_i && w_dims_ok;

  assign w_row_last_n = (r_row == RW'(r_n) - RW'(1));
  assign w_row_last_c = (r_row == r_nc - RW'(1));
  assign w_col_last   = (r_col == r_ng - CLW'(1));
  assign w_ng_zero    = (r_ng == '0);
  assign w_nc_zero    = (r_nc == '0);
  assign w_row_in_z   = (r_row < {1'b0, r_znc});
  assign w_col_in_z   = (r_col < {1'b0, r_zng});

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CENTER;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      S_CENTER: begin
        if (w_row_last_n) begin
          w_row_nxt = '0;
          if (!w_ng_zero)      w_state_nxt = S_GEN;
          else if (!w_nc_zero) w_state_nxt = S_BVEC;
          else                 w_state_nxt = S_DRAIN;
        end else begin
          w_row_nxt = r_row + RW'(1);
        end
      end
      S_GEN: begin
        if (w_col_last) begin
          w_col_nxt = '0;
          if (w_row_last_n) begin
            w_row_nxt   = '0;
            w_state_nxt = w_nc_zero ? S_DRAIN : S_AMAT;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end else begin
          w_col_nxt = r_col + CLW'(1);
        end
      end
      S_AMAT: begin
        if (w_col_last) begin
          w_col_nxt = '0;
          if (w_row_last_c) begin
            w_row_nxt   = '0;
            w_state_nxt = S_BVEC;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end else begin
          w_col_nxt = r_col + CLW'(1);
        end
      end
      S_BVEC: begin
        if (w_row_last_c) begin
          w_row_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_row_nxt = r_row + RW'(1);
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort_i && !w_idle) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
    end
  end

  always_comb begin
    busy_o  = !w_idle;
    done_o  = (r_state == S_DONE);
    err_o   = r_err;
    rd_en_o = 1'b0;
    phase_o = 2'd0;
    row_o   = '0;
    col_o   = '0;
    src_w_o = 1'b0;
    zero_o  = 1'b0;
    unique case (r_state)
      S_CENTER: begin
        rd_en_o = 1'b1;
        phase_o = 2'd0;
        row_o   = r_row;
      end
      S_GEN: begin
        rd_en_o = 1'b1;
        phase_o = 2'd1;
        row_o   = r_row;
        col_o   = r_col;
        src_w_o = !w_col_in_z;
      end
      S_AMAT: begin
        rd_en_o = 1'b1;
        phase_o = 2'd2;
        row_o   = r_row;
        col_o   = r_col;
        src_w_o = !w_row_in_z;
        zero_o  = (w_row_in_z != w_col_in_z);
      end
      S_BVEC: begin
        rd_en_o = 1'b1;
        phase_o = 2'd3;
        row_o   = r_row;
        src_w_o = !w_row_in_z;
      end
      default: begin
      end
    endcase
  end

  // Operand sizes are captured only on an accepted start; a rejected start leaves them untouched.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_n   <= '0;
      r_ng  <= '0;
      r_nc  <= '0;
      r_zng <= '0;
      r_znc <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_idle && start_i && !w_dims_ok;
      if (w_accept) begin
        r_n   <= Zn_i;
        r_ng  <= w_ng_in;
        r_nc  <= w_nc_in;
        r_zng <= Zng_i;
        r_znc <= Znc_i;
      end
    end
  end

  // Write side trails the read side by one cycle to cover the source memory read latency.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_en_o    <= 1'b0;
      wr_phase_o <= 2'd0;
      wr_row_o   <= '0;
      wr_col_o   <= '0;
      wr_src_w_o <= 1'b0;
      wr_zero_o  <= 1'b0;
    end else begin
      wr_en_o    <= rd_en_o;
      wr_phase_o <= phase_o;
      wr_row_o   <= row_o;
      wr_col_o   <= col_o;
      wr_src_w_o <= src_w_o;
      wr_zero_o  <= zero_o;
    end
  end

endmodule

// File: tb/tb_czono_plus_seq.sv
// Self-checking bench for czono_plus_seq: scoreboarded read/write index streams
// plus per-cycle handshake profiles for each scenario.
module tb_czono_plus_seq;

  localparam int NMAX  = 3;
  localparam int NGMAX = 15;
  localparam int NCMAX = 12;
  localparam int NW    = $clog2(NMAX);
  localparam int GW    = $clog2(NGMAX);
  localparam int CW    = $clog2(NCMAX);
  localparam int RW    = CW + 1;
  localparam int CLW   = GW + 1;
  localparam int MAXC  = 64;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic          abort_i;
  logic [NW-1:0] Zn_i, Wn_i;
  logic [GW-1:0] Zng_i, Wng_i;
  logic [CW-1:0] Znc_i, Wnc_i;
  logic          busy_o, done_o, err_o;
  logic          rd_en_o;
  logic [1:0]    phase_o;
  logic [CW:0]   row_o;
  logic [GW:0]   col_o;
  logic          src_w_o, zero_o;
  logic          wr_en_o;
  logic [1:0]    wr_phase_o;
  logic [CW:0]   wr_row_o;
  logic [GW:0]   wr_col_o;
  logic          wr_src_w_o, wr_zero_o;

  typedef struct packed {
    logic [1:0]     phase;
    logic [RW-1:0]  row;
    logic [CLW-1:0] col;
    logic           src;
    logic           zero;
  } acc_t;

  acc_t rd_q[$];
  acc_t wr_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic       rec_rd   [MAXC];
  logic       rec_wr   [MAXC];
  logic       rec_busy [MAXC];
  logic       rec_done [MAXC];
  logic       rec_err  [MAXC];
  logic       rec_src  [MAXC];
  logic       rec_zero [MAXC];
  logic [1:0] rec_phase[MAXC];
  logic       rst_snap;

  czono_plus_seq dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .Zn_i       (Zn_i),
    .Wn_i       (Wn_i),
    .Zng_i      (Zng_i),
    .Wng_i      (Wng_i),
    .Znc_i      (Znc_i),
    .Wnc_i      (Wnc_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rd_en_o    (rd_en_o),
    .phase_o    (phase_o),
    .row_o      (row_o),
    .col_o      (col_o),
    .src_w_o    (src_w_o),
    .zero_o     (zero_o),
    .wr_en_o    (wr_en_o),
    .wr_phase_o (wr_phase_o),
    .wr_row_o   (wr_row_o),
    .wr_col_o   (wr_col_o),
    .wr_src_w_o (wr_src_w_o),
    .wr_zero_o  (wr_zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every issued read and write must match the next expected access in order.
  always @(negedge clk_i) begin
    acc_t got;
    acc_t exp;
    if (rd_en_o) begin
      got = {phase_o, row_o, col_o, src_w_o, zero_o};
      tests_run++;
      if (rd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rd_unexpected: got %h, required no read", got);
      end else begin
        exp = rd_q.pop_front();
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL rd_access: got ph=%0d r=%0d c=%0d s=%b z=%b, required ph=%0d r=%0d c=%0d s=%b z=%b",
                   got.phase, got.row, got.col, got.src, got.zero,
                   exp.phase, exp.row, exp.col, exp.src, exp.zero);
        end
      end
    end
    if (wr_en_o) begin
      got = {wr_phase_o, wr_row_o, wr_col_o, wr_src_w_o, wr_zero_o};
      tests_run++;
      if (wr_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wr_unexpected: got %h, required no write", got);
      end else begin
        exp = wr_q.pop_front();
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL wr_access: got ph=%0d r=%0d c=%0d s=%b z=%b, required ph=%0d r=%0d c=%0d s=%b z=%b",
                   got.phase, got.row, got.col, got.src, got.zero,
                   exp.phase, exp.row, exp.col, exp.src, exp.zero);
        end
      end
    end
  end

  task automatic push_acc(input int ph, input int r, input int c, input bit s, input bit z);
    acc_t a;
    a.phase = 2'(ph);
    a.row   = RW'(r);
    a.col   = CLW'(c);
    a.src   = s;
    a.zero  = z;
    rd_q.push_back(a);
    wr_q.push_back(a);
  endtask

  // Reference access order built straight from the phase definitions.
  task automatic push_model(input int n, input int zng, input int wng, input int znc, input int wnc);
    int ng;
    int nc;
    ng = zng + wng;
    nc = znc + wnc;
    for (int r = 0; r < n; r++) push_acc(0, r, 0, 1'b0, 1'b0);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < ng; c++) push_acc(1, r, c, c >= zng, 1'b0);
    for (int r = 0; r < nc; r++)
      for (int c = 0; c < ng; c++) push_acc(2, r, c, r >= znc, (r < znc) != (c < zng));
    for (int r = 0; r < nc; r++) push_acc(3, r, 0, r >= znc, 1'b0);
  endtask

  task automatic record(input int c);
    rec_rd[c]    = rd_en_o;
    rec_wr[c]    = wr_en_o;
    rec_busy[c]  = busy_o;
    rec_done[c]  = done_o;
    rec_err[c]   = err_o;
    rec_src[c]   = src_w_o;
    rec_zero[c]  = zero_o;
    rec_phase[c] = phase_o;
  endtask

  // Start is driven in cycle 0 and sampled at the edge ending it; cycle c is observed after c edges.
  task automatic drive_run(input int zn, input int wn, input int zng, input int wng,
                           input int znc, input int wnc, input int abort_at,
                           input int rst_at, input int start_until, input int ncyc);
    @(negedge clk_i); #1;
    Zn_i  = NW'(zn);
    Wn_i  = NW'(wn);
    Zng_i = GW'(zng);
    Wng_i = GW'(wng);
    Znc_i = CW'(znc);
    Wnc_i = CW'(wnc);
    start_i = 1'b1;
    record(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk_i); #1;
      record(c);
      if (c == start_until) start_i = 1'b0;
      abort_i = (c == abort_at);
      if (c == rst_at) begin
        rstn_i = 1'b0;
        #1;
        rst_snap = |{busy_o, done_o, err_o, rd_en_o, phase_o, row_o, col_o, src_w_o, zero_o,
                     wr_en_o, wr_phase_o, wr_row_o, wr_col_o, wr_src_w_o, wr_zero_o};
      end
      if (rst_at >= 0 && c == rst_at + 2) rstn_i = 1'b1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  // Expected {rd, wr, busy, done, err} for a clean run whose start is sampled at cycle t0.
  function automatic logic [4:0] prof(input int c, input int t0, input int len);
    logic rd, wr, busy, done;
    rd   = (c >= t0 + 1) && (c <= t0 + len);
    wr   = (c >= t0 + 2) && (c <= t0 + len + 1);
    busy = (c >= t0 + 1) && (c <= t0 + len + 2);
    done = (c == t0 + len + 2);
    return {rd, wr, busy, done, 1'b0};
  endfunction

  function automatic logic [4:0] obs(input int c);
    return {rec_rd[c], rec_wr[c], rec_busy[c], rec_done[c], rec_err[c]};
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    v = {busy_o, done_o, err_o, rd_en_o, phase_o, row_o, col_o, src_w_o, zero_o,
         wr_en_o, wr_phase_o, wr_row_o, wr_col_o, wr_src_w_o, wr_zero_o};
    tests_run++;
    if (v !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, required 0", v);
    end
    @(negedge clk_i); #1;
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    tests_run++;
    if ({busy_o, rd_en_o, done_o, err_o} !== 4'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %b, required 0000", {busy_o, rd_en_o, done_o, err_o});
    end
  endtask

  task automatic test_basic();
    push_model(2, 1, 1, 1, 1);
    drive_run(2, 2, 1, 1, 1, 1, -1, -1, 1, 16);
    for (int c = 0; c <= 16; c++) begin
      tests_run++;
      if (obs(c) !== prof(c, 0, 12)) begin
        tests_failed++;
        $display("FAIL basic_profile c=%0d: got %b, required %b", c, obs(c), prof(c, 0, 12));
      end
    end
    tests_run++;
    if ({rec_zero[7], rec_zero[8], rec_zero[9], rec_zero[10]} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL basic_amat_zero: got %b, required 0110",
               {rec_zero[7], rec_zero[8], rec_zero[9], rec_zero[10]});
    end
    tests_run++;
    if ({rec_src[3], rec_src[4], rec_src[5], rec_src[6]} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL basic_gen_src: got %b, required 0101",
               {rec_src[3], rec_src[4], rec_src[5], rec_src[6]});
    end
    tests_run++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_drained: got rd=%0d wr=%0d left, required 0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_dim_error();
    int dims[4][6] = '{'{2, 1, 1, 1, 1, 1}, '{2, 2, 8, 8, 1, 1},
                       '{0, 0, 1, 1, 0, 0}, '{1, 1, 0, 0, 6, 7}};
    for (int k = 0; k < 4; k++) begin
      drive_run(dims[k][0], dims[k][1], dims[k][2], dims[k][3], dims[k][4], dims[k][5],
                -1, -1, 1, 5);
      for (int c = 0; c <= 5; c++) begin
        tests_run++;
        if (obs(c) !== {4'b0000, c == 1}) begin
          tests_failed++;
          $display("FAIL dim_error k=%0d c=%0d: got %b, required %b", k, c, obs(c), {4'b0000, c == 1});
        end
      end
    end
  endtask

  task automatic test_small();
    push_model(1, 1, 0, 0, 0);
    drive_run(1, 1, 1, 0, 0, 0, -1, -1, 1, 6);
    for (int c = 0; c <= 6; c++) begin
      tests_run++;
      if (obs(c) !== prof(c, 0, 2)) begin
        tests_failed++;
        $display("FAIL small_profile c=%0d: got %b, required %b", c, obs(c), prof(c, 0, 2));
      end
      if (rec_rd[c] === 1'b1) begin
        tests_run++;
        if (rec_phase[c] > 2'd1) begin
          tests_failed++;
          $display("FAIL small_phase c=%0d: got %0d, required <=1", c, rec_phase[c]);
        end
      end
    end
    tests_run++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL small_drained: got rd=%0d wr=%0d left, required 0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_capacity_limits();
    push_model(1, 8, 7, 0, 0);
    drive_run(1, 1, 8, 7, 0, 0, -1, -1, 1, 19);
    for (int c = 0; c <= 19; c++) begin
      tests_run++;
      if (obs(c) !== prof(c, 0, 16)) begin
        tests_failed++;
        $display("FAIL ngmax_profile c=%0d: got %b, required %b", c, obs(c), prof(c, 0, 16));
      end
    end
    push_model(1, 1, 0, 6, 6);
    drive_run(1, 1, 1, 0, 6, 6, -1, -1, 1, 28);
    for (int c = 0; c <= 28; c++) begin
      tests_run++;
      if (obs(c) !== prof(c, 0, 26)) begin
        tests_failed++;
        $display("FAIL ncmax_profile c=%0d: got %b, required %b", c, obs(c), prof(c, 0, 26));
      end
    end
    tests_run++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL limits_drained: got rd=%0d wr=%0d left, required 0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp;
    push_model(2, 1, 1, 1, 1);
    drive_run(2, 2, 1, 1, 1, 1, 4, -1, 1, 10);
    for (int c = 0; c <= 10; c++) begin
      exp = (c <= 4) ? prof(c, 0, 12) : {1'b0, c == 5, 3'b000};
      tests_run++;
      if (obs(c) !== exp) begin
        tests_failed++;
        $display("FAIL abort_profile c=%0d: got %b, required %b", c, obs(c), exp);
      end
    end
    tests_run++;
    if (rd_q.size() != 8 || wr_q.size() != 8) begin
      tests_failed++;
      $display("FAIL abort_count: got rd=%0d wr=%0d left, required 8 8", rd_q.size(), wr_q.size());
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic test_back_to_back();
    push_model(2, 1, 1, 1, 1);
    push_model(2, 1, 1, 1, 1);
    drive_run(2, 2, 1, 1, 1, 1, -1, -1, 16, 31);
    for (int c = 0; c <= 31; c++) begin
      tests_run++;
      if (obs(c) !== (prof(c, 0, 12) | prof(c, 15, 12))) begin
        tests_failed++;
        $display("FAIL b2b_profile c=%0d: got %b, required %b", c, obs(c),
                 prof(c, 0, 12) | prof(c, 15, 12));
      end
    end
    tests_run++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_drained: got rd=%0d wr=%0d left, required 0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    push_model(2, 1, 1, 1, 1);
    drive_run(2, 2, 1, 1, 1, 1, -1, 7, 1, 20);
    tests_run++;
    if (rst_snap !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %b, required 0", rst_snap);
    end
    for (int c = 0; c <= 20; c++) begin
      exp = (c <= 7) ? prof(c, 0, 12) : 5'b00000;
      tests_run++;
      if (obs(c) !== exp) begin
        tests_failed++;
        $display("FAIL async_reset_profile c=%0d: got %b, required %b", c, obs(c), exp);
      end
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
    rstn_i  = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    Zn_i    = '0;
    Wn_i    = '0;
    Zng_i   = '0;
    Wng_i   = '0;
    Znc_i   = '0;
    Wnc_i   = '0;
    rst_snap = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    test_reset();
    test_basic();
    test_dim_error();
    test_small();
    test_capacity_limits();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
